spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_tick_gen.sv | 36 +++
 rtl/spi_master.sv | 208 ++++++++++++++++++++
 tb/tb_spi_master.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and the master state type for the SPI read master.
package spi_pkg;

    localparam int SPI_ADDR_W     = 8;
    localparam int SPI_DATA_W     = 32;
    localparam int SPI_FRAME_W    = 40;   // 8 address clocks + 32 data clocks
    localparam int SPI_DATA_START = 9;    // first SPI_CLK rise whose MISO sample is kept
    localparam int SPI_BITCNT_W   = 6;    // counts rising edges 0..40
    localparam int SPI_DIV_W      = 8;    // holds HALF_DIV-1 and GAP_CYC-1 (max 254)

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_XFER,
        ST_CS_HOLD,
        ST_GAP
    } spi_state_e;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period divider: while enabled, pulses tick once every HALF_DIV Clk
// cycles. The count restarts after every tick (i.e. on every SPI_CLK toggle)
// and whenever enable drops, so each phase is exactly HALF_DIV cycles long.
module spi_tick_gen
    import spi_pkg::*;
#(
    parameter int HALF_DIV = 4
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic enable,
    output logic tick
);

    logic [SPI_DIV_W-1:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == SPI_DIV_W'(HALF_DIV - 1));

    // Next count: reload on tick or while idle, else advance.
    always_comb begin
        cnt_d = cnt_q + SPI_DIV_W'(1);
        if (!enable || tick) begin
            cnt_d = '0;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 read master: sends an 8-bit address MSB first, then clocks in a
// 32-bit word. Frame = CS setup (HALF_DIV) + 40 SPI_CLK periods + CS hold
// (HALF_DIV), so SPI_CS is low for exactly 82*HALF_DIV cycles, followed by a
// GAP_CYC-cycle gap with Busy still high.
// Optional build macro SPI_MASTER_MISO_SYNC_EN: passes SPI_MISO through a
// 2-flop synchronizer before sampling (requires HALF_DIV >= 4).
module spi_master
    import spi_pkg::*;
#(
    parameter int HALF_DIV = 4,
    parameter int GAP_CYC  = 8
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Start,
    input  logic [SPI_ADDR_W-1:0] Addr,
    output logic                  Busy,
    output logic                  Done,
    output logic [SPI_DATA_W-1:0] DataFromSlave,
    output logic                  SPI_CLK,
    output logic                  SPI_CS,
    output logic                  SPI_MOSI,
    input  logic                  SPI_MISO
);

    localparam logic [SPI_BITCNT_W-1:0] LAST_RISE  = SPI_BITCNT_W'(SPI_FRAME_W);
    localparam logic [SPI_BITCNT_W-1:0] FIRST_KEEP = SPI_BITCNT_W'(SPI_DATA_START - 1);
    localparam logic [SPI_DIV_W-1:0]    GAP_LAST   = SPI_DIV_W'(GAP_CYC - 1);

    generate
        if (HALF_DIV < 2 || HALF_DIV > 255) begin : g_bad_half_div
            $error("spi_master: HALF_DIV must be within 2..255");
        end
        if (GAP_CYC < 1 || GAP_CYC > 255) begin : g_bad_gap_cyc
            $error("spi_master: GAP_CYC must be within 1..255");
        end
    endgenerate

    spi_state_e                state_q, state_d;
    logic [SPI_ADDR_W-1:0]     addr_q, addr_d;
    logic [SPI_BITCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SPI_DIV_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic [SPI_DATA_W-1:0]     shift_q, shift_d;
    logic [SPI_DATA_W-1:0]     data_q, data_d;
    logic                      sclk_q, sclk_d;
    logic                      cs_q, cs_d;
    logic                      mosi_q, mosi_d;
    logic                      done_q, done_d;
    logic                      tick;
    logic                      tick_en;
    logic                      miso_s;

`ifdef SPI_MASTER_MISO_SYNC_EN
    logic [1:0] miso_sync_q;

    generate
        if (HALF_DIV < 4) begin : g_bad_sync_div
            $error("spi_master: SPI_MASTER_MISO_SYNC_EN requires HALF_DIV >= 4");
        end
    endgenerate

    // Two-stage synchronizer on the asynchronous slave data line.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            miso_sync_q <= '0;
        end else begin
            miso_sync_q <= {miso_sync_q[0], SPI_MISO};
        end
    end

    assign miso_s = miso_sync_q[1];
`else
    assign miso_s = SPI_MISO;
`endif

    // Divider runs only while CS is asserted; it restarts from zero each frame.
    assign tick_en = (state_q == ST_CS_SETUP) || (state_q == ST_XFER) ||
                     (state_q == ST_CS_HOLD);

    spi_tick_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_tick_gen (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .enable  (tick_en),
        .tick    (tick)
    );

    // Next-state and registered-output logic for the frame sequencer.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cs_d   = 1'b1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                if (Start) begin
                    addr_d    = Addr;
                    mosi_d    = Addr[SPI_ADDR_W-1];
                    cs_d      = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = ST_CS_SETUP;
                end
            end

            ST_CS_SETUP: begin
                // First rise; its MISO sample is an address-phase bit and is dropped.
                if (tick) begin
                    sclk_d    = 1'b1;
                    bit_cnt_d = SPI_BITCNT_W'(1);
                    state_d   = ST_XFER;
                end
            end

            ST_XFER: begin
                if (tick) begin
                    if (sclk_q) begin
                        // Falling edge: present next address bit, zero-filled after bit 0.
                        sclk_d = 1'b0;
                        mosi_d = addr_q[SPI_ADDR_W-2];
                        addr_d = {addr_q[SPI_ADDR_W-2:0], 1'b0};
                    end else if (bit_cnt_q == LAST_RISE) begin
                        // 40th low phase complete; hold CS with the clock parked low.
                        state_d = ST_CS_HOLD;
                    end else begin
                        sclk_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q + SPI_BITCNT_W'(1);
                        if (bit_cnt_q >= FIRST_KEEP) begin
                            shift_d = {shift_q[SPI_DATA_W-2:0], miso_s};
                        end
                    end
                end
            end

            ST_CS_HOLD: begin
                if (tick) begin
                    cs_d      = 1'b1;
                    mosi_d    = 1'b0;
                    data_d    = shift_q;
                    done_d    = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + SPI_DIV_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight without Done.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            mosi_q    <= mosi_d;
            done_q    <= done_d;
        end
    end

    assign Busy          = (state_q != ST_IDLE);
    assign Done          = done_q;
    assign DataFromSlave = data_q;
    assign SPI_CLK       = sclk_q;
    assign SPI_CS        = cs_q;
    assign SPI_MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: a behavioural mode-0 slave serves
// {junk byte, 32-bit word} per frame, and a bus monitor records frame
// shape (CS low length, clock phases, MOSI bits at each rise, CS gaps).
module tb_spi_master;

  localparam int H        = 4;
  localparam int G        = 8;
  localparam int CS_LOW   = 82 * H;
  localparam int BUSY_LEN = 82 * H + G;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Start;
  logic [7:0]  Addr;
  logic        Busy;
  logic        Done;
  logic [31:0] DataFromSlave;
  logic        SPI_CLK;
  logic        SPI_CS;
  logic        SPI_MOSI;
  logic        SPI_MISO;

  always #5 Clk = ~Clk;

  spi_master #(.HALF_DIV(H), .GAP_CYC(G)) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .Start         (Start),
    .Addr          (Addr),
    .Busy          (Busy),
    .Done          (Done),
    .DataFromSlave (DataFromSlave),
    .SPI_CLK       (SPI_CLK),
    .SPI_CS        (SPI_CS),
    .SPI_MOSI      (SPI_MOSI),
    .SPI_MISO      (SPI_MISO)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave data for the next frame (written by the stimulus, latched at CS fall).
  logic [31:0] slv_word;
  logic [7:0]  slv_junk;

  // Monitor results (written only by the monitor).
  int          frames_total  = 0;
  int          done_total    = 0;
  int          bad_phase     = 0;
  int          done_misalign = 0;
  int          last_cs_low   = 0;
  int          last_rises    = 0;
  logic [39:0] last_mosi     = '0;
  int          gap_q[$];

  // Bus monitor and mode-0 slave: slave shifts out MSB first, changing on falls.
  initial begin : mon
    logic        prev_cs, prev_sclk;
    int          cs_low, cs_high, rises, phase, idx;
    logic [39:0] mbits, sframe;
    prev_cs = 1'b1; prev_sclk = 1'b0;
    cs_low = 0; cs_high = 0; rises = 0; phase = 0; idx = 39;
    mbits = '0; sframe = '0;
    SPI_MISO = 1'b0;
    forever begin
      @(negedge Clk);
      if (Done === 1'b1) begin
        done_total++;
        if (!(prev_cs == 1'b0 && SPI_CS == 1'b1)) done_misalign++;
      end
      if (SPI_CS == 1'b0) begin
        if (prev_cs) begin
          gap_q.push_back(cs_high);
          cs_low = 0; rises = 0; mbits = '0; phase = 0; idx = 39;
          sframe = {slv_junk, slv_word};
          SPI_MISO = sframe[39];
        end
        cs_low++;
        if (SPI_CLK != prev_sclk) begin
          if (phase != H) bad_phase++;
          phase = 1;
          if (SPI_CLK) begin
            rises++;
            mbits = {mbits[38:0], SPI_MOSI};
          end else begin
            if (idx > 0) idx--;
            SPI_MISO = sframe[idx];
          end
        end else begin
          phase++;
        end
      end else begin
        if (!prev_cs) begin
          frames_total++;
          last_cs_low = cs_low;
          last_rises  = rises;
          last_mosi   = mbits;
          cs_high     = 0;
        end
        cs_high++;
      end
      prev_cs   = SPI_CS;
      prev_sclk = SPI_CLK;
    end
  end

  // One single-Start frame; optionally pulses Start at busy cycles 5/100/300.
  task automatic run_frame(input string tag, input logic [7:0] a, input logic [31:0] w,
                           input bit pulses);
    int d0, f0, b0, m0, blen, dseen;
    logic [31:0] dval;
    d0 = done_total; f0 = frames_total; b0 = bad_phase; m0 = done_misalign;
    slv_word = w;
    slv_junk = 8'($urandom);
    Addr  = a;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    Addr  = 8'($urandom);
    chk({tag, "/busy_rise"}, 64'(Busy), 64'(1));
    chk({tag, "/cs_fall"}, 64'(SPI_CS), 64'(0));
    chk({tag, "/mosi_b7"}, 64'(SPI_MOSI), 64'(a[7]));
    blen = 0; dseen = 0; dval = '0;
    while (Busy && blen < 2000) begin
      blen++;
      Start = pulses && (blen == 5 || blen == 100 || blen == 300);
      if (Done) begin
        dseen++;
        dval = DataFromSlave;
      end
      @(negedge Clk);
    end
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    chk({tag, "/busy_len"}, 64'(blen), 64'(BUSY_LEN));
    chk({tag, "/done_seen"}, 64'(dseen), 64'(1));
    chk({tag, "/data_at_done"}, 64'(dval), 64'(w));
    chk({tag, "/data_hold"}, 64'(DataFromSlave), 64'(w));
    chk({tag, "/frames"}, 64'(frames_total - f0), 64'(1));
    chk({tag, "/dones"}, 64'(done_total - d0), 64'(1));
    chk({tag, "/cs_low"}, 64'(last_cs_low), 64'(CS_LOW));
    chk({tag, "/rises"}, 64'(last_rises), 64'(40));
    chk({tag, "/mosi"}, 64'(last_mosi), 64'({a, 32'h0}));
    chk({tag, "/phase"}, 64'(bad_phase - b0), 64'(0));
    chk({tag, "/done_cs"}, 64'(done_misalign - m0), 64'(0));
    chk({tag, "/idle_cs"}, 64'(SPI_CS), 64'(1));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] w3 [3];
    logic [7:0]  a;
    int k, cyc, q0, f0, d0, r;
    logic prev;

    Reset_n = 1'b0; Start = 1'b0; Addr = '0;
    slv_word = '0; slv_junk = '0;
    repeat (3) @(negedge Clk);
    chk("rst/cs", 64'(SPI_CS), 64'(1));
    chk("rst/sclk", 64'(SPI_CLK), 64'(0));
    chk("rst/mosi", 64'(SPI_MOSI), 64'(0));
    chk("rst/busy", 64'(Busy), 64'(0));
    chk("rst/done", 64'(Done), 64'(0));
    chk("rst/data", 64'(DataFromSlave), 64'(0));
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Directed words, then random address/data.
    run_frame("a5", 8'hA5, 32'hDEADBEEF, 1'b0);
    run_frame("lsb", 8'h3C, 32'h00000001, 1'b0);
    run_frame("msb", 8'hC3, 32'h80000000, 1'b0);
    for (int i = 0; i < 5; i++) run_frame("rnd", 8'($urandom), $urandom, 1'b0);

    // Start while busy must be ignored.
    run_frame("ign", 8'($urandom), $urandom, 1'b1);

    // Start held high: three back-to-back frames.
    for (int i = 0; i < 3; i++) w3[i] = $urandom;
    a = 8'($urandom);
    q0 = gap_q.size(); f0 = frames_total;
    slv_word = w3[0]; slv_junk = 8'($urandom);
    Addr = a; Start = 1'b1;
    k = 0; cyc = 0;
    while (k < 3 && cyc < 1500) begin
      @(negedge Clk);
      cyc++;
      if (Done) begin
        chk("b2b/data", 64'(DataFromSlave), 64'(w3[k]));
        k++;
        if (k < 3) slv_word = w3[k];
        else Start = 1'b0;
      end
    end
    Start = 1'b0;
    chk("b2b/dones", 64'(k), 64'(3));
    cyc = 0;
    while (Busy && cyc < 100) begin
      @(negedge Clk);
      cyc++;
    end
    repeat (4) @(negedge Clk);
    chk("b2b/frames", 64'(frames_total - f0), 64'(3));
    chk("b2b/gap_cnt", 64'(gap_q.size() - q0), 64'(3));
    chk("b2b/gap1", 64'(gap_q[q0 + 1]), 64'(G + 1));
    chk("b2b/gap2", 64'(gap_q[q0 + 2]), 64'(G + 1));
    chk("b2b/mosi", 64'(last_mosi), 64'({a, 32'h0}));

    // Reset mid-frame at the 20th rise: abort with no Done.
    slv_word = $urandom; slv_junk = 8'($urandom);
    Addr = 8'($urandom); Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    r = 0; cyc = 0; prev = SPI_CLK;
    while (r < 20 && cyc < 2000) begin
      @(negedge Clk);
      cyc++;
      if (SPI_CLK && !prev) r++;
      prev = SPI_CLK;
    end
    chk("mid/reach20", 64'(r), 64'(20));
    d0 = done_total;
    Reset_n = 1'b0;
    @(negedge Clk);
    chk("mid/cs", 64'(SPI_CS), 64'(1));
    chk("mid/sclk", 64'(SPI_CLK), 64'(0));
    chk("mid/busy", 64'(Busy), 64'(0));
    chk("mid/done", 64'(Done), 64'(0));
    chk("mid/mosi", 64'(SPI_MOSI), 64'(0));
    chk("mid/data", 64'(DataFromSlave), 64'(0));
    Reset_n = 1'b1;
    repeat (20) @(negedge Clk);
    chk("mid/no_done", 64'(done_total - d0), 64'(0));
    chk("mid/abort_rises", 64'(last_rises), 64'(20));
    chk("mid/idle_busy", 64'(Busy), 64'(0));
    run_frame("post_rst", 8'($urandom), $urandom, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
